// File: rtl/camo_key_pkg.sv
// Shared types and helpers for the camouflage key loader.
// Holds the loader state encoding, the default key width and the parity helper.
package camo_key_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam int KEY_W_DEFAULT = 12;

    // Even-parity bit of a key; zero-extension leaves the result unchanged for narrower keys.
    function automatic logic even_par(input logic [63:0] key);
        return ^key;
    endfunction

endpackage

// File: rtl/camo_key_timer.sv
// Idle-timeout counter for the key frame receiver.
// o_expired flags the idle cycle on which the count reaches TIMEOUT.
module camo_key_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_count;

    // Saturating count so the timer can never wrap back into the accepting range.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != TW'(TIMEOUT))) begin
            r_count <= r_count + TW'(1);
        end
    end

    assign o_expired = i_en && (r_count >= TW'(TIMEOUT - 1));

endmodule

// File: rtl/camo_key_loader.sv
// Serial-in key loader: stages a parity-protected frame in a shadow register and
// commits it to the camouflage key bus only after the frame checks clean.
module camo_key_loader
    import camo_key_pkg::*;
#(
    parameter int               KEY_W      = KEY_W_DEFAULT,
    parameter int               TIMEOUT    = 16,
    parameter logic [KEY_W-1:0] KEY_RST    = '0,
    parameter int               WRITE_ONCE = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load_start,
    input  logic             i_bit_valid,
    input  logic             i_bit_data,
    output logic             o_bit_ready,
    output logic [KEY_W-1:0] o_key_out,
    output logic             o_load_busy,
    output logic             o_load_done,
    output logic             o_load_err,
    output logic             o_key_locked
);

    localparam int CW = $clog2(KEY_W + 1);

    state_t           r_state;
    logic [KEY_W-1:0] r_shadow;
    logic             r_parity;
    logic [CW-1:0]    r_cnt;
    logic [KEY_W-1:0] r_key;
    logic             r_done;
    logic             r_err;
    logic             r_locked;

    logic w_xfer;
    logic w_timerClr;
    logic w_timerEn;
    logic w_expired;

    assign o_bit_ready = (r_state == SHIFT) && !i_load_start;
    assign w_xfer      = i_bit_valid && o_bit_ready;
    assign w_timerClr  = (r_state != SHIFT) || w_xfer || i_load_start;
    assign w_timerEn   = (r_state == SHIFT) && !w_xfer && !i_load_start;

    camo_key_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (w_timerClr),
        .i_en     (w_timerEn),
        .o_expired(w_expired)
    );

    // A restart in SHIFT takes priority over both a bit transfer and the timeout abort.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_shadow <= '0;
            r_parity <= 1'b0;
            r_cnt    <= '0;
            r_key    <= KEY_RST;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_load_start) begin
                        if (r_locked) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state  <= SHIFT;
                            r_shadow <= '0;
                            r_cnt    <= '0;
                        end
                    end
                end
                SHIFT: begin
                    if (i_load_start) begin
                        r_shadow <= '0;
                        r_cnt    <= '0;
                    end else if (w_xfer) begin
                        if (r_cnt < CW'(KEY_W)) begin
                            for (int i = 0; i < KEY_W; i++) begin
                                if (r_cnt == CW'(i)) begin
                                    r_shadow[i] <= i_bit_data;
                                end
                            end
                        end else begin
                            r_parity <= i_bit_data;
                            r_state  <= CHECK;
                        end
                        r_cnt <= r_cnt + CW'(1);
                    end else if (w_expired) begin
                        r_state <= IDLE;
                        r_err   <= 1'b1;
                    end
                end
                CHECK: begin
                    if (even_par(64'(r_shadow)) == r_parity) begin
                        r_key    <= r_shadow;
                        r_done   <= 1'b1;
                        r_locked <= r_locked || (WRITE_ONCE != 0);
                    end else begin
                        r_err <= 1'b1;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_key_out    = r_key;
    assign o_load_busy  = (r_state != IDLE);
    assign o_load_done  = r_done;
    assign o_load_err   = r_err;
    assign o_key_locked = r_locked;

endmodule

// File: tb/tb_camo_key_loader.sv
// Directed self-checking bench for camo_key_loader (KEY_W=12, TIMEOUT=16, KEY_RST=0).
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
module tb_camo_key_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        loadStart = 1'b0;
    logic        bitValid = 1'b0;
    logic        bitData = 1'b0;
    logic        bitReady;
    logic [11:0] keyOut;
    logic        loadBusy;
    logic        loadDone;
    logic        loadErr;
    logic        keyLocked;

    int   nTests = 0;
    int   nFail = 0;
    logic lastReady;

    camo_key_loader #(
        .KEY_W(12),
        .TIMEOUT(16),
        .KEY_RST(12'h000),
        .WRITE_ONCE(1)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_load_start(loadStart),
        .i_bit_valid(bitValid),
        .i_bit_data(bitData),
        .o_bit_ready(bitReady),
        .o_key_out(keyOut),
        .o_load_busy(loadBusy),
        .o_load_done(loadDone),
        .o_load_err(loadErr),
        .o_key_locked(keyLocked)
    );

    always #5 clk = ~clk;

    // One clock cycle with the given inputs; bit_ready is captured before the edge.
    task automatic applyStimulus(input logic s, input logic v, input logic d);
        loadStart = s;
        bitValid  = v;
        bitData   = d;
        #1;
        lastReady = bitReady;
        @(posedge clk);
        #1;
    endtask

    task automatic sendBits(input logic [12:0] frame, input int first, input int count);
        for (int i = first; i < first + count; i++) begin
            applyStimulus(1'b0, 1'b1, frame[i]);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        if (keyOut !== 12'h000) begin $display("[TB] FAIL reset_key: got %h expected %h", keyOut, 12'h000); nFail++; end
        nTests++;
        if (loadBusy !== 1'b0) begin $display("[TB] FAIL reset_busy: got %b expected 0", loadBusy); nFail++; end
        nTests++;
        if ({loadDone, loadErr, keyLocked} !== 3'b000) begin
            $display("[TB] FAIL reset_flags: got done/err/locked=%b expected 000", {loadDone, loadErr, keyLocked}); nFail++;
        end
        nTests++;
        if (lastReady !== 1'b0) begin $display("[TB] FAIL reset_ready: got %b expected 0", lastReady); nFail++; end
        nTests++;
        rst = 1'b0;
    endtask

    task automatic test_bad_parity();
        applyStimulus(1'b1, 1'b0, 1'b0);
        sendBits({1'b1, 12'hA5C}, 0, 13);
        applyStimulus(1'b0, 1'b0, 1'b0);
        if ({loadErr, loadDone} !== 2'b10) begin
            $display("[TB] FAIL badpar_pulse: got err/done=%b expected 10", {loadErr, loadDone}); nFail++;
        end
        nTests++;
        if (keyOut !== 12'h000) begin $display("[TB] FAIL badpar_key: got %h expected %h", keyOut, 12'h000); nFail++; end
        nTests++;
        if (keyLocked !== 1'b0) begin $display("[TB] FAIL badpar_locked: got %b expected 0", keyLocked); nFail++; end
        nTests++;
        applyStimulus(1'b0, 1'b0, 1'b0);
        if (loadErr !== 1'b0) begin $display("[TB] FAIL badpar_err_width: got %b expected 0", loadErr); nFail++; end
        nTests++;
    endtask

    task automatic test_timeout();
        applyStimulus(1'b1, 1'b0, 1'b0);
        sendBits({1'b0, 12'h3F0}, 0, 5);
        for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        if ({loadBusy, loadErr} !== 2'b10) begin
            $display("[TB] FAIL timeout_early: got busy/err=%b expected 10 after 15 idle", {loadBusy, loadErr}); nFail++;
        end
        nTests++;
        applyStimulus(1'b0, 1'b0, 1'b0);
        if ({loadBusy, loadErr, loadDone} !== 3'b010) begin
            $display("[TB] FAIL timeout_abort: got busy/err/done=%b expected 010", {loadBusy, loadErr, loadDone}); nFail++;
        end
        nTests++;
        if (keyOut !== 12'h000) begin $display("[TB] FAIL timeout_key: got %h expected %h", keyOut, 12'h000); nFail++; end
        nTests++;
        applyStimulus(1'b1, 1'b0, 1'b0);
        sendBits({1'b0, 12'h3F0}, 0, 13);
        applyStimulus(1'b0, 1'b0, 1'b0);
        if ({keyOut, loadDone} !== {12'h3F0, 1'b1}) begin
            $display("[TB] FAIL timeout_reload: got key=%h done=%b expected key=3f0 done=1", keyOut, loadDone); nFail++;
        end
        nTests++;
    endtask

    task automatic test_restart();
        applyStimulus(1'b1, 1'b0, 1'b0);
        sendBits({1'b0, 12'hFFF}, 0, 7);
        applyStimulus(1'b1, 1'b1, 1'b1);
        if (lastReady !== 1'b0) begin $display("[TB] FAIL restart_ready: got %b expected 0", lastReady); nFail++; end
        nTests++;
        sendBits({1'b1, 12'h001}, 0, 13);
        applyStimulus(1'b0, 1'b0, 1'b0);
        if ({keyOut, loadDone, loadErr} !== {12'h001, 2'b10}) begin
            $display("[TB] FAIL restart_key: got key=%h done=%b err=%b expected key=001 done=1 err=0", keyOut, loadDone, loadErr); nFail++;
        end
        nTests++;
    endtask

    task automatic test_good_frame();
        applyStimulus(1'b1, 1'b0, 1'b0);
        if (loadBusy !== 1'b1) begin $display("[TB] FAIL good_busy: got %b expected 1", loadBusy); nFail++; end
        nTests++;
        sendBits({1'b0, 12'hA5C}, 0, 1);
        if (lastReady !== 1'b1) begin $display("[TB] FAIL good_ready: got %b expected 1", lastReady); nFail++; end
        nTests++;
        sendBits({1'b0, 12'hA5C}, 1, 12);
        if ({keyOut, loadDone, loadBusy} !== {12'h000, 2'b01}) begin
            $display("[TB] FAIL good_latency: got key=%h done=%b busy=%b expected key=000 done=0 busy=1", keyOut, loadDone, loadBusy); nFail++;
        end
        nTests++;
        applyStimulus(1'b0, 1'b0, 1'b0);
        if (keyOut !== 12'hA5C) begin $display("[TB] FAIL good_key: got %h expected %h", keyOut, 12'hA5C); nFail++; end
        nTests++;
        if ({loadDone, loadErr, keyLocked, loadBusy} !== 4'b1010) begin
            $display("[TB] FAIL good_flags: got done/err/locked/busy=%b expected 1010", {loadDone, loadErr, keyLocked, loadBusy}); nFail++;
        end
        nTests++;
        applyStimulus(1'b0, 1'b0, 1'b0);
        if (loadDone !== 1'b0) begin $display("[TB] FAIL good_done_width: got %b expected 0", loadDone); nFail++; end
        nTests++;
    endtask

    task automatic test_write_once();
        applyStimulus(1'b1, 1'b0, 1'b0);
        if ({loadErr, loadBusy} !== 2'b10) begin
            $display("[TB] FAIL wonce_refuse: got err/busy=%b expected 10", {loadErr, loadBusy}); nFail++;
        end
        nTests++;
        applyStimulus(1'b0, 1'b1, 1'b1);
        if ({lastReady, loadErr} !== 2'b00) begin
            $display("[TB] FAIL wonce_ready: got ready/err=%b expected 00", {lastReady, loadErr}); nFail++;
        end
        nTests++;
        if (keyOut !== 12'hA5C) begin $display("[TB] FAIL wonce_hold: got %h expected %h", keyOut, 12'hA5C); nFail++; end
        nTests++;
        doReset();
        if ({keyOut, keyLocked} !== {12'h000, 1'b0}) begin
            $display("[TB] FAIL wonce_reset: got key=%h locked=%b expected key=000 locked=0", keyOut, keyLocked); nFail++;
        end
        nTests++;
        applyStimulus(1'b1, 1'b0, 1'b0);
        sendBits({1'b0, 12'hA5C}, 0, 13);
        applyStimulus(1'b0, 1'b0, 1'b0);
        if ({keyOut, loadDone} !== {12'hA5C, 1'b1}) begin
            $display("[TB] FAIL wonce_reload: got key=%h done=%b expected key=a5c done=1", keyOut, loadDone); nFail++;
        end
        nTests++;
    endtask

    task automatic test_reset_mid_frame();
        logic sawPulse;
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0);
        sendBits({1'b0, 12'h3F0}, 0, 9);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b1);
        rst = 1'b0;
        if ({keyOut, loadBusy, loadDone, loadErr, keyLocked} !== {12'h000, 4'b0000}) begin
            $display("[TB] FAIL midrst_outputs: got key=%h busy/done/err/locked=%b expected 000/0000",
                     keyOut, {loadBusy, loadDone, loadErr, keyLocked}); nFail++;
        end
        nTests++;
        sawPulse = 1'b0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            if (loadDone || loadErr || lastReady) sawPulse = 1'b1;
        end
        if (sawPulse !== 1'b0) begin $display("[TB] FAIL midrst_quiet: got activity=%b expected 0", sawPulse); nFail++; end
        nTests++;
    endtask

    initial begin
        test_reset();
        test_bad_parity();
        test_timeout();
        doReset();
        test_restart();
        doReset();
        test_good_frame();
        test_write_once();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
